// File: rtl/mode_counter.sv
// Multi-mode sequencing counter: wrap-up, wrap-down, saturate-up and ping-pong,
// with programmable modulus, synchronous load, terminal-count pulse and wrap tally.
module mode_counter #(
    parameter int WIDTH   = 5,
    parameter int MOD     = 32,
    parameter int RST_VAL = 0,
    parameter int WRAP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  cnt,
    output logic              dir,
    output logic              tc,
    output logic              sat,
    output logic [WRAP_W-1:0] wraps
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    dir_t             state, state_nx;
    logic [WIDTH-1:0] cnt_nx;
    logic [WIDTH-1:0] cur;
    logic             wrap_ev;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= WIDTH'(RST_VAL);
            state <= UP;
            tc    <= 1'b0;
            wraps <= '0;
        end else begin
            cnt   <= cnt_nx;
            state <= state_nx;
            tc    <= wrap_ev;
            if (wrap_ev && (wraps != '1))
                wraps <= wraps + WRAP_W'(1);
        end
    end

    // An out-of-range count left over from a different modulus steps as if it were TOP.
    always_comb begin
        cur      = (cnt > TOP) ? TOP : cnt;
        cnt_nx   = cnt;
        state_nx = state;
        wrap_ev  = 1'b0;
        if (load) begin
            cnt_nx   = (load_val > TOP) ? TOP : load_val;
            state_nx = (mode == 2'b01) ? DOWN : UP;
        end else if (en) begin
            case (mode)
                2'b00: begin
                    state_nx = UP;
                    if (cur == TOP) begin
                        cnt_nx  = '0;
                        wrap_ev = 1'b1;
                    end else begin
                        cnt_nx = cur + ONE;
                    end
                end
                2'b01: begin
                    state_nx = DOWN;
                    if (cur == '0) begin
                        cnt_nx  = TOP;
                        wrap_ev = 1'b1;
                    end else begin
                        cnt_nx = cur - ONE;
                    end
                end
                2'b10: begin
                    state_nx = UP;
                    cnt_nx   = (cur == TOP) ? cur : cur + ONE;
                end
                default: begin
                    if (state == UP) begin
                        if (cur == TOP) begin
                            cnt_nx   = cur - ONE;
                            state_nx = DOWN;
                            wrap_ev  = 1'b1;
                        end else begin
                            cnt_nx = cur + ONE;
                        end
                    end else begin
                        if (cur == '0) begin
                            cnt_nx   = cur + ONE;
                            state_nx = UP;
                            wrap_ev  = 1'b1;
                        end else begin
                            cnt_nx = cur - ONE;
                        end
                    end
                end
            endcase
        end
    end

    assign dir = state;
    assign sat = (mode == 2'b10) && (cnt == TOP);

endmodule
